// File: rtl/n64adv2_clk_mon_pkg.sv
// rtl/n64adv2_clk_mon_pkg.sv - shared state encodings and per-instance default windows for n64adv2_clk_mon
package n64adv2_clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_CHECK    = 2'd1,
    ST_LOCKED   = 2'd2
  } clk_mon_state_e;

  // Counts are toggle edges (monitored clock / 2 each) per window of system clocks.
  localparam int HDMI_WINDOW_LEN   = 1024;
  localparam int HDMI_CNT_MIN      = 500;
  localparam int HDMI_CNT_MAX      = 524;

  localparam int DRAM_WINDOW_LEN   = 1024;
  localparam int DRAM_CNT_MIN      = 980;
  localparam int DRAM_CNT_MAX      = 1068;

  localparam int AUDIO_WINDOW_LEN  = 4096;
  localparam int AUDIO_CNT_MIN     = 90;
  localparam int AUDIO_CNT_MAX     = 110;

  localparam int DEF_GOOD_WINDOWS  = 4;
  localparam int DEF_STALL_LEN     = 64;

endpackage

// File: rtl/n64adv2_tgl_sync.sv
// rtl/n64adv2_tgl_sync.sv - two-flop synchronizer plus history flop; flags either toggle transition
module n64adv2_tgl_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic tgl_async_i,
  output logic edge_o
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else if (clk_en) begin
      sync1 <= tgl_async_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_o = sync2 ^ hist;

endmodule

// File: rtl/n64adv2_clk_mon.sv
// rtl/n64adv2_clk_mon.sv - windowed edge-count clock monitor with debounced ok and loss pulse
// Optional sticky loss flag built when N64ADV2_CLK_MON_STICKY_EN is defined.
module n64adv2_clk_mon
  import n64adv2_clk_mon_pkg::*;
#(
  parameter int WINDOW_LEN   = 1024,
  parameter int CNT_W        = 16,
  parameter int CNT_MIN      = 500,
  parameter int CNT_MAX      = 524,
  parameter int GOOD_WINDOWS = 4,
  parameter int STALL_LEN    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             tgl_async_i,
  output logic [CNT_W-1:0] meas_o,
  output logic             meas_valid_o,
  output logic             clk_ok_o,
  output logic             clk_lost_o,
  output logic [1:0]       state_o
`ifdef N64ADV2_CLK_MON_STICKY_EN
  ,
  input  logic             lost_clr_i,
  output logic             lost_sticky_o
`endif
);

  localparam int WIN_W   = $clog2(WINDOW_LEN);
  localparam int STALL_W = $clog2(STALL_LEN + 1);
  localparam int GOOD_W  = $clog2(GOOD_WINDOWS + 1);

  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_LEN);
  localparam logic [GOOD_W-1:0]  GOOD_LIM  = GOOD_W'(GOOD_WINDOWS);
  localparam logic [CNT_W-1:0]   CNT_SAT   = '1;
  localparam logic [CNT_W-1:0]   CNT_LO    = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0]   CNT_HI    = CNT_W'(CNT_MAX);

  logic                 tgl_edge;
  logic [WIN_W-1:0]     win_cnt;
  logic [CNT_W-1:0]     edge_cnt;
  logic [CNT_W-1:0]     edge_cnt_incl;
  logic [STALL_W-1:0]   stall_cnt;
  logic [STALL_W-1:0]   stall_nxt;
  logic [GOOD_W-1:0]    good_cnt;
  logic [GOOD_W-1:0]    good_nxt;
  logic [GOOD_W-1:0]    good_inc;
  clk_mon_state_e       state_q;
  clk_mon_state_e       state_nxt;
  logic                 win_end;
  logic                 win_good;
  logic                 stall_hit;
  logic                 lost_nxt;
  logic [CNT_W-1:0]     meas_q;
  logic                 meas_valid_q;
  logic                 clk_ok_q;
  logic                 lost_q;

  n64adv2_tgl_sync u_tgl_sync (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .tgl_async_i (tgl_async_i),
    .edge_o      (tgl_edge)
  );

  // Edge in the terminal cycle belongs to the closing window, so judge the inclusive count.
  assign win_end       = (win_cnt == WIN_LAST);
  assign edge_cnt_incl = (tgl_edge && (edge_cnt != CNT_SAT)) ? edge_cnt + 1'b1 : edge_cnt;
  assign win_good      = (edge_cnt_incl >= CNT_LO) && (edge_cnt_incl <= CNT_HI);

  assign stall_nxt = tgl_edge ? '0 :
                     (stall_cnt == STALL_LIM) ? stall_cnt : stall_cnt + 1'b1;
  assign stall_hit = (stall_nxt == STALL_LIM);
  assign good_inc  = good_cnt + 1'b1;

  always_comb begin
    state_nxt = state_q;
    good_nxt  = good_cnt;
    lost_nxt  = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (win_end && win_good) begin
          if (GOOD_WINDOWS == 1) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
          end else begin
            state_nxt = ST_CHECK;
            good_nxt  = GOOD_W'(1);
          end
        end
      end
      ST_CHECK: begin
        if (win_end) begin
          if (!win_good) begin
            state_nxt = ST_UNLOCKED;
            good_nxt  = '0;
          end else if (good_inc == GOOD_LIM) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt  = good_inc;
          end
        end
      end
      ST_LOCKED: begin
        // A stall and a bad window end in the same cycle still yield one pulse.
        if (stall_hit || (win_end && !win_good)) begin
          state_nxt = ST_UNLOCKED;
          good_nxt  = '0;
          lost_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_UNLOCKED;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt      <= '0;
      edge_cnt     <= '0;
      stall_cnt    <= '0;
      good_cnt     <= '0;
      state_q      <= ST_UNLOCKED;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      clk_ok_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else if (clk_en) begin
      win_cnt      <= win_end ? '0 : win_cnt + 1'b1;
      edge_cnt     <= win_end ? '0 : edge_cnt_incl;
      stall_cnt    <= stall_nxt;
      good_cnt     <= good_nxt;
      state_q      <= state_nxt;
      meas_valid_q <= win_end;
      clk_ok_q     <= (state_nxt == ST_LOCKED);
      lost_q       <= lost_nxt;
      if (win_end) begin
        meas_q <= edge_cnt_incl;
      end
    end
  end

  assign meas_o       = meas_q;
  assign meas_valid_o = meas_valid_q & clk_en;
  assign clk_ok_o     = clk_ok_q;
  assign clk_lost_o   = lost_q & clk_en;
  assign state_o      = state_q;

`ifdef N64ADV2_CLK_MON_STICKY_EN
  logic lost_sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lost_sticky_q <= 1'b0;
    end else if (clk_en) begin
      if (lost_nxt) begin
        lost_sticky_q <= 1'b1;
      end else if (lost_clr_i) begin
        lost_sticky_q <= 1'b0;
      end
    end
  end

  assign lost_sticky_o = lost_sticky_q;
`endif

endmodule

// File: tb/tb_n64adv2_clk_mon.sv
// tb/tb_n64adv2_clk_mon.sv - directed self-checking bench for n64adv2_clk_mon
module tb_n64adv2_clk_mon;

  localparam int WIN   = 64;
  localparam int CW    = 16;
  localparam int STALL = 8;

  logic          clk;
  logic          rst;
  logic          clk_en;
  logic          tgl;
  logic [CW-1:0] meas_o;
  logic          meas_valid_o;
  logic          clk_ok_o;
  logic          clk_lost_o;
  logic [1:0]    state_o;
  logic          lost_clr;
`ifdef N64ADV2_CLK_MON_STICKY_EN
  logic          lost_sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pos      = 0;
  int k        = -1;
  int prev_k   = -1;
  bit first_win = 1'b1;
  int last_tgl = 0;
  int clr_at   = -1;
  int lost_cnt = 0;
  int lost_at  = 0;
  int win_idx  = 0;

  n64adv2_clk_mon #(
    .WINDOW_LEN   (WIN),
    .CNT_W        (CW),
    .CNT_MIN      (30),
    .CNT_MAX      (34),
    .GOOD_WINDOWS (3),
    .STALL_LEN    (STALL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .tgl_async_i  (tgl),
    .meas_o       (meas_o),
    .meas_valid_o (meas_valid_o),
    .clk_ok_o     (clk_ok_o),
    .clk_lost_o   (clk_lost_o),
    .state_o      (state_o)
`ifdef N64ADV2_CLK_MON_STICKY_EN
    ,
    .lost_clr_i   (lost_clr),
    .lost_sticky_o(lost_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pos <= rst ? 0 : ((pos == WIN - 1) ? 0 : pos + 1);
  end

  always @(negedge clk) begin
    if (clk_lost_o) begin
      lost_cnt <= lost_cnt + 1;
      lost_at  <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pattern k: toggle every cycle for positions < k, then every other cycle; k < 0 stops.
  function automatic bit tog(input int kk, input int p);
    if (kk < 0) return 1'b0;
    return (p < kk) || (((p - kk) % 2) == 0);
  endfunction

  // Edges are seen two cycles late, so positions 62..63 land in the following window.
  function automatic int exp_count(input int pk, input int ck, input bit first);
    int n = 0;
    if (!first) begin
      for (int p = WIN - 2; p < WIN; p++) if (tog(pk, p)) n++;
    end
    for (int p = 0; p < WIN - 2; p++) if (tog(ck, p)) n++;
    return n;
  endfunction

  task automatic tick();
    if (k >= 0 && tog(k, pos)) begin
      tgl = ~tgl;
      last_tgl = cyc;
    end
    lost_clr = (cyc == clr_at);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tgl = 1'b0;
    k   = -1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    first_win = 1'b1;
    prev_k    = -1;
  endtask

  task automatic run_window(input int kk, input int exp_state);
    int early = 0;
    int exp_m;
    exp_m = exp_count(prev_k, kk, first_win);
    k = kk;
    for (int i = 0; i < WIN; i++) begin
      if (i > 0 && meas_valid_o) early++;
      tick();
    end
    win_idx++;
    check_eq($sformatf("early_valid w%0d", win_idx), early, 0);
    check_eq($sformatf("meas_valid w%0d", win_idx), meas_valid_o, 1);
    check_eq($sformatf("meas w%0d", win_idx), meas_o, exp_m);
    check_eq($sformatf("state w%0d", win_idx), state_o, exp_state);
    check_eq($sformatf("clk_ok w%0d", win_idx), clk_ok_o, (exp_state == 2) ? 1 : 0);
    prev_k = kk;
    first_win = 1'b0;
  endtask

  initial begin
    int l0;
    rst = 1'b1;
    clk_en = 1'b1;
    tgl = 1'b0;
    lost_clr = 1'b0;
    @(negedge clk);
    check_eq("rst meas", meas_o, 0);
    check_eq("rst valid", meas_valid_o, 0);
    check_eq("rst ok", clk_ok_o, 0);
    check_eq("rst lost", clk_lost_o, 0);
    check_eq("rst state", state_o, 0);

    // Toggle every 2 cycles: lock after the third good window.
    do_reset();
    run_window(0, 1);
    run_window(0, 1);
    run_window(0, 2);
    run_window(0, 2);
    run_window(0, 2);
    check_eq("no_loss_locked", lost_cnt, 0);

    // Toggle stops while locked.
    l0 = lost_cnt;
    run_window(-1, 0);
    check_eq("stall pulses", lost_cnt - l0, 1);
    check_eq("stall latency", lost_at - last_tgl, STALL + 3);

    // Toggle every cycle: too fast, never leaves UNLOCKED.
    do_reset();
    run_window(64, 0);
    run_window(64, 0);
    run_window(64, 0);

    // 32, 32, 40, 32, 32, 32.
    do_reset();
    l0 = lost_cnt;
    run_window(0, 1);
    run_window(0, 1);
    run_window(16, 0);
    run_window(0, 1);
    run_window(0, 1);
    run_window(0, 2);
    check_eq("no_loss_bad_window", lost_cnt - l0, 0);

    // Reset mid-window while locked.
    k = 0;
    repeat (20) tick();
    rst = 1'b1;
    tgl = 1'b0;
    k = -1;
    @(negedge clk);
    check_eq("midrst meas", meas_o, 0);
    check_eq("midrst valid", meas_valid_o, 0);
    check_eq("midrst ok", clk_ok_o, 0);
    check_eq("midrst lost", clk_lost_o, 0);
    check_eq("midrst state", state_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_win = 1'b1;
    prev_k = -1;
    run_window(0, 1);

`ifdef N64ADV2_CLK_MON_STICKY_EN
    run_window(0, 1);
    run_window(0, 2);
    check_eq("sticky idle", lost_sticky, 0);
    run_window(-1, 0);
    check_eq("sticky set", lost_sticky, 1);
    run_window(0, 1);
    run_window(0, 1);
    run_window(0, 2);
    check_eq("sticky relock", lost_sticky, 1);
    clr_at = cyc;
    tick();
    check_eq("sticky clr", lost_sticky, 0);
    k = 0;
    while (pos != 0) tick();
    first_win = 1'b0;
    prev_k = 0;
    run_window(0, 2);
    clr_at = last_tgl + STALL + 2;
    run_window(-1, 0);
    check_eq("sticky set_wins", lost_sticky, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
